// File: rtl/add_serial_pkg.sv
// add_serial_pkg: shared FSM states, counter sizing and saturation limits for add_serial
package add_serial_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction
endpackage

// File: rtl/fa_bit.sv
// fa_bit: combinational 1-bit full adder
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/add_serial.sv
// add_serial: bit-serial signed adder, LSB first, with overflow flag.
// Define ADD_SERIAL_SATURATE_EN to clamp the sum on overflow instead of wrapping.
module add_serial
    import add_serial_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);
    localparam int CW = clog2(WIDTH);
`ifdef ADD_SERIAL_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_P = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_N = WIDTH'(sat_min(WIDTH));
`endif

    state_t           state;
    logic [WIDTH-1:0] ra, rb;
    logic [CW-1:0]    cnt;
    logic             carry, s, co;
    logic [WIDTH-1:0] sum_next;

    fa_bit u_fa (.a(ra[0]), .b(rb[0]), .cin(carry), .s(s), .cout(co));

    assign sum_next = {s, sum[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            overflow  <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra       <= a;
                    rb       <= b;
                    carry    <= 1'b0;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    carry <= co;
                    cnt   <= cnt + 1'b1;
                    sum   <= sum_next;
                    // last bit: carry holds the carry into the MSB, co the carry out
                    if (cnt == CW'(WIDTH - 1)) begin
                        overflow  <= carry ^ co;
`ifdef ADD_SERIAL_SATURATE_EN
                        sum       <= (carry ^ co) ? (ra[0] ? SAT_N : SAT_P) : sum_next;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_serial.sv
// tb_add_serial: randomized and exhaustive check of add_serial against an integer model
module tb_add_serial;
    localparam int W  = 6;
    localparam int HI = (1 << (W - 1)) - 1;
    localparam int LO = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, overflow;
    logic [W-1:0] sum;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    add_serial #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .overflow(overflow)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input int av, input int bv, output int es, output int eo);
        int t;
        t  = av + bv;
        eo = (t > HI || t < LO) ? 1 : 0;
`ifdef ADD_SERIAL_SATURATE_EN
        if (eo == 1) t = (av >= 0) ? HI : LO;
`endif
        es = (t > HI) ? t - (1 << W) : (t < LO) ? t + (1 << W) : t;
    endfunction

    task automatic op(input int av, input int bv, input int hold, input string tag);
        int n, es, eo;
        logic [W-1:0] hs;
        logic ho;
        model(av, bv, es, eo);
        check({tag, ".rdy"}, in_ready, 1);
        a = W'(av);
        b = W'(bv);
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        n = 0;
        while (!out_valid && n < 4 * W) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".lat"}, n, W);
        check({tag, ".sum"}, $signed(sum), es);
        check({tag, ".ovf"}, overflow, eo);
        hs = sum;
        ho = overflow;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            check({tag, ".hold"}, {out_valid, in_ready, ho, sum}, {1'b1, 1'b0, ho, hs});
            check({tag, ".hovf"}, overflow, ho);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".done"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst.rdy", in_ready, 1);
        check("rst.ov", out_valid, 0);
        check("rst.sum", sum, 0);
        check("rst.ovf", overflow, 0);
        rst_n = 1'b1;
        op(5, 7, 0, "t1");
        op(31, 1, 0, "t2a");
        op(-32, -1, 0, "t2b");
        op(31, 31, 0, "t2c");
        op(-32, -32, 0, "t2d");
        op(-20, 20, 0, "t3a");
        op(-32, 31, 0, "t3b");
        op(9, -3, 5, "t4a");
        op(3, 4, 0, "t4b");
        // abort an operation mid-shift with a one-edge reset
        a = W'(17);
        b = W'(9);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t5.rdy", in_ready, 1);
        check("t5.ov", out_valid, 0);
        check("t5.sum", sum, 0);
        seen = 0;
        repeat (2 * W) begin
            @(posedge clk); #1;
            seen += int'(out_valid);
        end
        check("t5.none", seen, 0);
        op(-1, -1, 0, "t5b");
        for (int i = LO; i <= HI; i++)
            for (int j = LO; j <= HI; j++)
                op(i, j, 0, "sweep");
        repeat (300)
            op(int'($urandom_range(2 * HI + 1)) + LO, int'($urandom_range(2 * HI + 1)) + LO,
               int'($urandom_range(3)), "rnd");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/add_serial.md
Name: add_serial

Overview:
- Bit-serial signed adder with overflow detection; the inverse (addition) counterpart of the team's combinational subtractor.
- Takes two WIDTH-bit two's-complement operands through a valid/ready handshake and adds them one bit per clock, LSB first.
- Returns the WIDTH-bit sum and an overflow flag through a second valid/ready handshake.
- Serves the project's multi-cycle arithmetic datapath where area matters more than latency.

Parameters:
WIDTH, 6, operand and result width in bits (signed range -(2^(WIDTH-1)) .. 2^(WIDTH-1)-1); legal values are 2 or more.

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  operands a and b are presented
in_ready  output  1  block is IDLE and can accept operands
a  input  WIDTH  signed operand a
b  input  WIDTH  signed operand b
out_valid  output  1  sum and overflow are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  signed a+b, truncated to WIDTH bits
overflow  output  1  true signed result lies outside the WIDTH-bit range

Behaviour:
- Clocking/reset: one clock, clk. Reset rst_n is synchronous and active-low. While rst_n=0 at a rising edge:
  - state becomes IDLE; in_ready=1, out_valid=0, sum=0, overflow=0;
  - bit counter and carry register are cleared.
- Reset asserted mid-operation (SHIFT or DONE) aborts the operation. The in-flight result is discarded and never presented.
- States:
  - IDLE: in_ready=1. The edge where in_valid=1 is the accept edge; it loads a and b into shift registers, clears carry, sets cnt=0 and moves to SHIFT.
  - SHIFT: in_ready=0. Each edge processes bit cnt:
    - s = a0^b0^c; carry register takes majority(a0,b0,c);
    - s shifts into the sum register from the MSB side;
    - the a and b registers shift right;
    - cnt increments.
  - SHIFT exit: on the edge with cnt==WIDTH-1, latch overflow = (carry into MSB) XOR (carry out of MSB), set out_valid=1 and move to DONE.
  - DONE: out_valid=1. sum and overflow are held stable while out_ready=0. On the first edge with out_ready=1, go to IDLE: out_valid=0, in_ready=1.
- Latency: out_valid rises exactly WIDTH edges after the accept edge. The earliest next accept is the edge after the result-consume edge. Throughput is one result per WIDTH+2 cycles.
- in_valid is ignored outside IDLE. a and b need only be stable at the accept edge.
- sum equals (a+b) mod 2^WIDTH in all cases, including overflow.
- Overflow cases:
  - positive+positive giving a negative result;
  - negative+negative giving a non-negative result;
  - mixed signs never overflow.
- Boundary: at WIDTH=6, 31+31 gives sum=-2, overflow=1; -32+-32 gives sum=0, overflow=1.
- sum is not guaranteed meaningful while out_valid=0; the bench samples it only when out_valid=1.

Optional Feature:
ADD_SERIAL_SATURATE_EN
- Defined:
  - on overflow, sum is clamped to the extreme of the operands' common sign: 2^(WIDTH-1)-1 when both are non-negative, -2^(WIDTH-1) when both are negative;
  - overflow is still reported as 1;
  - clamping is applied on the SHIFT-exit edge, so latency is unchanged.
- Undefined: wrap-around sum as specified above.

Decomposition:
- Shared package add_serial_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - counter width function clog2(WIDTH);
  - saturation constants SAT_MAX/SAT_MIN as functions of WIDTH.
- One sub-module, fa_bit: a combinational 1-bit full adder with inputs a, b, cin and outputs s, cout.
- add_serial holds the FSM, the shift registers and the carry flop.

Test Plan:
1. Reset, then a=5, b=7 with out_ready=1 -> out_valid exactly 6 edges after accept, sum=12, overflow=0; in_ready=1 the following cycle.
2. a=31, b=1 -> sum=-32, overflow=1 (with ADD_SERIAL_SATURATE_EN: sum=31, overflow=1). Also a=-32, b=-1 -> sum=31, overflow=1 (saturated: -32).
3. a=-20, b=20 -> sum=0, overflow=0. Also a=-32, b=31 -> sum=-1, overflow=0.
4. Hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b -> sum and overflow stay stable, in_ready=0, no new accept. Then out_ready=1 -> IDLE; a new operation (3+4) yields 7.
5. Drop rst_n for one edge at SHIFT cnt=3 -> out_valid=0, in_ready=1, sum=0 on the next cycle. A fresh operation (-1 + -1) returns -2, overflow=0.
6. Exhaustive sweep over all 64x64 operand pairs, back-to-back with out_ready=1 -> every sum and overflow matches the integer model; no lost or duplicated results.
